// File: rtl/lb_host_seq_if.sv
// Host sequencer request/response channels and localbus.
// master = sequencer, slave = request source plus responder.
interface lb_host_seq_if #(
  parameter int AW   = 24,
  parameter int DW   = 32,
  parameter int LENW = 8
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            req_rnw;
  logic [LENW-1:0] req_len;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_last;
  logic [AW-1:0]   lb_addr;
  logic [DW-1:0]   lb_wdata;
  logic            lb_write;
  logic            lb_control_strobe;
  logic            lb_control_rd;
  logic [DW-1:0]   lb_rdata;
  logic            lb_rvalid;
  logic            busy;

  modport master (
    input  req_valid, req_addr, req_wdata, req_rnw, req_len,
    input  rsp_ready, lb_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_last,
    output lb_addr, lb_wdata, lb_write, lb_control_strobe,
    output lb_control_rd, lb_rvalid, busy
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_rnw, req_len,
    output rsp_ready, lb_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last,
    input  lb_addr, lb_wdata, lb_write, lb_control_strobe,
    input  lb_control_rd, lb_rvalid, busy
  );
endinterface

// File: rtl/lb_host_seq.sv
// Localbus initiator: turns request/response handshakes into
// strobe/write/rd cycles, single beats or incrementing bursts.
module lb_host_seq #(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int READ_DELAY = 3,
  parameter int LENW       = 8
) (
  input logic           clk,
  input logic           rst_n,
  lb_host_seq_if.master bus
);
  localparam int CW = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;

  typedef enum logic [2:0] {
    IDLE, STROBE, WAIT, RESP, WFILL
  } state_t;

  state_t          st_q, st_d;
  logic [CW-1:0]   dly_q, dly_d;
  logic [LENW-1:0] beats_q, beats_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rdy_q, rdy_d;
  logic            vld_q, vld_d;
  logic            last_q, last_d;
  logic            stb_q, stb_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            rv_q, rv_d;
  logic            busy_q, busy_d;

  // Next state and next registered outputs; strobe qualifiers
  // default low so they only ever accompany a strobe.
  always_comb begin
    st_d    = st_q;
    dly_d   = dly_q;
    beats_d = beats_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    vld_d   = vld_q;
    last_d  = last_q;
    stb_d   = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    rv_d    = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          beats_d = bus.req_len;
          stb_d   = 1'b1;
          if (bus.req_rnw) begin
            st_d = STROBE;
            rd_d = 1'b1;
          end else begin
            st_d = WFILL;
            wr_d = 1'b1;
          end
        end
      end
      STROBE: begin
        st_d  = WAIT;
        dly_d = CW'(READ_DELAY - 1);
        rv_d  = (READ_DELAY == 1);
      end
      WAIT: begin
        if (dly_q == '0) begin
          st_d    = RESP;
          rdata_d = bus.lb_rdata;
          vld_d   = 1'b1;
          last_d  = (beats_q == '0);
        end else begin
          dly_d = dly_q - CW'(1);
          rv_d  = (dly_q == CW'(1));
        end
      end
      WFILL: begin
        if (beats_q == '0) begin
          st_d    = RESP;
          rdata_d = '0;
          vld_d   = 1'b1;
          last_d  = 1'b1;
        end else begin
          beats_d = beats_q - LENW'(1);
          addr_d  = addr_q + AW'(1);
          stb_d   = 1'b1;
          wr_d    = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          vld_d  = 1'b0;
          last_d = 1'b0;
          if (last_q) begin
            st_d = IDLE;
          end else begin
            st_d    = STROBE;
            beats_d = beats_q - LENW'(1);
            addr_d  = addr_q + AW'(1);
            stb_d   = 1'b1;
            rd_d    = 1'b1;
          end
        end
      end
      default: st_d = IDLE;
    endcase
    rdy_d  = (st_d == IDLE);
    busy_d = (st_d != IDLE);
  end

  // State, counters and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      dly_q   <= '0;
      beats_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      stb_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      dly_q   <= dly_d;
      beats_q <= beats_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      stb_q   <= stb_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready         = rdy_q;
  assign bus.rsp_valid         = vld_q;
  assign bus.rsp_rdata         = rdata_q;
  assign bus.rsp_last          = last_q;
  assign bus.lb_addr           = addr_q;
  assign bus.lb_wdata          = wdata_q;
  assign bus.lb_write          = wr_q;
  assign bus.lb_control_strobe = stb_q;
  assign bus.lb_control_rd     = rd_q;
  assign bus.lb_rvalid         = rv_q;
  assign bus.busy              = busy_q;
endmodule

// File: tb/tb_lb_host_seq.sv
// Bench for lb_host_seq: directed and random transactions against
// a transaction-level model plus pipelined responders.
module tb_lb_host_seq;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int LENW = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lb_host_seq_if #(.AW(AW), .DW(DW), .LENW(LENW)) b1 ();
  lb_host_seq_if #(.AW(AW), .DW(DW), .LENW(LENW)) b2 ();

  lb_host_seq #(.AW(AW), .DW(DW), .READ_DELAY(D), .LENW(LENW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  lb_host_seq #(.AW(AW), .DW(DW), .READ_DELAY(1), .LENW(LENW)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] salt;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    if (a == 24'h000010) return 32'hCAFEF00D;
    return ({8'h00, a} * 32'h9E3779B1) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responders: read data valid exactly D (or 1) cycles after the strobe.
  logic [D-1:0]  pv1 = '0;
  logic [DW-1:0] pd1 [D];
  logic [DW-1:0] junk1 = '0;
  logic          pv2 = 1'b0;
  logic [DW-1:0] pd2 = '0;
  logic [DW-1:0] junk2 = '0;
  always @(posedge clk) begin
    pv1 <= {pv1[D-2:0], b1.lb_control_strobe & b1.lb_control_rd};
    pd1[0] <= mem(b1.lb_addr);
    for (int i = 1; i < D; i++) pd1[i] <= pd1[i-1];
    junk1 <= $urandom;
    pv2 <= b2.lb_control_strobe & b2.lb_control_rd;
    pd2 <= mem(b2.lb_addr);
    junk2 <= $urandom;
  end
  assign b1.lb_rdata = pv1[D-1] ? pd1[D-1] : junk1;
  assign b2.lb_rdata = pv2 ? pd2 : junk2;

  typedef struct {
    int c; logic [AW-1:0] a; logic w; logic r; logic [DW-1:0] d;
  } stb_t;
  typedef struct { int c; logic [DW-1:0] d; logic l; } rsp_t;

  stb_t sq[$];
  rsp_t rq[$];
  int   rvq[$];
  int   qual_bad = 0;
  int   hold_bad = 0;
  logic hv = 1'b0;
  logic hr = 1'b0;
  logic [DW-1:0] hd = '0;
  int   s2c[$];
  int   r2c[$];
  logic [DW-1:0] d2[$];

  // Bus monitors, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (b1.lb_control_strobe === 1'b1) begin
      sq.push_back('{c: cyc, a: b1.lb_addr, w: b1.lb_write,
                     r: b1.lb_control_rd, d: b1.lb_wdata});
      if (b1.lb_write & b1.lb_control_rd) qual_bad++;
      if (b1.rsp_valid) qual_bad++;
    end else if (b1.lb_write === 1'b1 || b1.lb_control_rd === 1'b1) begin
      qual_bad++;
    end
    if (b1.lb_rvalid === 1'b1) rvq.push_back(cyc);
    if (b1.rsp_valid === 1'b1 && b1.rsp_ready === 1'b1)
      rq.push_back('{c: cyc, d: b1.rsp_rdata, l: b1.rsp_last});
    if (hv && !hr && (b1.rsp_valid !== 1'b1 || b1.rsp_rdata !== hd))
      hold_bad++;
    hv = (b1.rsp_valid === 1'b1);
    hr = (b1.rsp_ready === 1'b1);
    hd = b1.rsp_rdata;
    if (b2.lb_control_strobe === 1'b1) s2c.push_back(cyc);
    if (b2.lb_rvalid === 1'b1) r2c.push_back(cyc);
    if (b2.rsp_valid === 1'b1 && b2.rsp_ready === 1'b1)
      d2.push_back(b2.rsp_rdata);
  end

  task automatic clear_mon();
    sq.delete();
    rq.delete();
    rvq.delete();
    qual_bad = 0;
    hold_bad = 0;
  endtask

  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic rnw, input int len, input bit rnd,
                         input string tag);
    int n;
    int budget;
    int acc;
    logic [AW-1:0] ea;
    n = rnw ? len + 1 : 1;
    budget = 50;
    while (b1.req_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, " idle"}, b1.req_ready, 1'b1);
    clear_mon();
    b1.req_valid = 1'b1;
    b1.req_addr = a;
    b1.req_wdata = wd;
    b1.req_rnw = rnw;
    b1.req_len = LENW'(len);
    b1.rsp_ready = rnd ? 1'($urandom) : 1'b1;
    tick();
    acc = cyc;
    b1.req_valid = 1'b0;
    b1.req_addr = AW'($urandom);
    b1.req_wdata = $urandom;
    budget = (len + 1) * 40 + 50;
    while (!(rq.size() > 0 && rq[$].l) && budget > 0) begin
      b1.rsp_ready = rnd ? 1'($urandom) : 1'b1;
      tick();
      budget--;
    end
    chk({tag, " done"}, budget > 0, 1'b1);
    b1.rsp_ready = 1'b0;
    repeat (4) tick();
    chk({tag, " nstrobe"}, sq.size(), len + 1);
    chk({tag, " nrsp"}, rq.size(), n);
    chk({tag, " nrvalid"}, rvq.size(), rnw ? len + 1 : 0);
    if (sq.size() > 0) chk({tag, " first_strobe"}, sq[0].c, acc + 1);
    for (int i = 0; i < sq.size() && i <= len; i++) begin
      ea = a + AW'(i);
      chk({tag, " addr"}, sq[i].a, ea);
      chk({tag, " wr"}, sq[i].w, !rnw);
      chk({tag, " rd"}, sq[i].r, rnw);
      if (!rnw) begin
        chk({tag, " wdata"}, sq[i].d, wd);
        chk({tag, " b2b"}, sq[i].c, sq[0].c + i);
      end else begin
        if (i < rvq.size()) chk({tag, " capture"}, rvq[i], sq[i].c + D);
        if (i > 0 && i - 1 < rq.size())
          chk({tag, " after_rsp"}, sq[i].c, rq[i-1].c + 1);
      end
    end
    for (int i = 0; i < rq.size() && i < n; i++) begin
      ea = a + AW'(i);
      chk({tag, " rdata"}, rq[i].d, rnw ? mem(ea) : '0);
      chk({tag, " last"}, rq[i].l, i == n - 1);
    end
    chk({tag, " qualifiers"}, qual_bad, 0);
    chk({tag, " rsp_hold"}, hold_bad, 0);
  endtask

  initial begin
    int budget;
    salt = $urandom;
    b1.req_valid = 1'b0;
    b1.req_addr = '0;
    b1.req_wdata = '0;
    b1.req_rnw = 1'b0;
    b1.req_len = '0;
    b1.rsp_ready = 1'b0;
    b2.req_valid = 1'b0;
    b2.req_addr = '0;
    b2.req_wdata = '0;
    b2.req_rnw = 1'b0;
    b2.req_len = '0;
    b2.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst req_ready", b1.req_ready, 1'b1);
    chk("rst busy", b1.busy, 1'b0);
    chk("rst strobe", b1.lb_control_strobe, 1'b0);
    chk("rst rsp_valid", b1.rsp_valid, 1'b0);
    chk("rst lb_addr", b1.lb_addr, '0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_txn(24'h000010, 32'h0, 1'b1, 0, 1'b0, "single_read");
    run_txn(24'h000100, 32'h0, 1'b1, 3, 1'b1, "read_burst");
    run_txn(24'h004000, 32'h42, 1'b0, 4, 1'b1, "write_fill");
    run_txn(24'hFFFFFE, 32'h0, 1'b1, 2, 1'b1, "wrap");
    run_txn(24'hFFFFF0, 32'h1234_5678, 1'b0, 255, 1'b1, "write_256");
    for (int k = 0; k < 8; k++)
      run_txn(AW'($urandom), $urandom, 1'($urandom), $urandom_range(0, 6),
              1'b1, "random");

    clear_mon();
    b1.req_valid = 1'b1;
    b1.req_addr = 24'h000200;
    b1.req_rnw = 1'b1;
    b1.req_len = 8'd7;
    b1.rsp_ready = 1'b1;
    tick();
    b1.req_valid = 1'b0;
    budget = 100;
    while (sq.size() < 2 && budget > 0) begin
      tick();
      budget--;
    end
    chk("mid_rst reach_beat2", sq.size(), 2);
    chk("mid_rst busy_before", b1.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst strobe", b1.lb_control_strobe, 1'b0);
    chk("mid_rst rd", b1.lb_control_rd, 1'b0);
    chk("mid_rst write", b1.lb_write, 1'b0);
    chk("mid_rst rvalid", b1.lb_rvalid, 1'b0);
    chk("mid_rst rsp_valid", b1.rsp_valid, 1'b0);
    chk("mid_rst rsp_last", b1.rsp_last, 1'b0);
    chk("mid_rst rsp_rdata", b1.rsp_rdata, '0);
    chk("mid_rst lb_addr", b1.lb_addr, '0);
    chk("mid_rst busy", b1.busy, 1'b0);
    chk("mid_rst req_ready", b1.req_ready, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (12) tick();
    chk("post_rst strobes", sq.size(), 0);
    chk("post_rst rsps", rq.size(), 0);
    chk("post_rst req_ready", b1.req_ready, 1'b1);
    run_txn(24'h000777, 32'hA5A5_0001, 1'b0, 0, 1'b0, "post_rst_write");

    s2c.delete();
    r2c.delete();
    d2.delete();
    b2.rsp_ready = 1'b1;
    b2.req_valid = 1'b1;
    b2.req_addr = 24'h000033;
    b2.req_rnw = 1'b1;
    b2.req_len = 8'd1;
    tick();
    b2.req_valid = 1'b0;
    budget = 50;
    while (d2.size() < 2 && budget > 0) begin
      tick();
      budget--;
    end
    repeat (3) tick();
    chk("rd1 nstrobe", s2c.size(), 2);
    chk("rd1 nrsp", d2.size(), 2);
    chk("rd1 nrvalid", r2c.size(), 2);
    if (s2c.size() == 2 && r2c.size() == 2) begin
      chk("rd1 capture0", r2c[0], s2c[0] + 1);
      chk("rd1 capture1", r2c[1], s2c[1] + 1);
      chk("rd1 period", s2c[1] - s2c[0], 3);
    end
    if (d2.size() == 2) begin
      chk("rd1 data0", d2[0], mem(24'h000033));
      chk("rd1 data1", d2[1], mem(24'h000034));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lb_host_seq.md
Name: lb_host_seq

Overview:
- Localbus initiator: the host side of the ghostbus localbus.
- Converts request/response handshakes into control_strobe / write / rd cycles.
- Reads return rdata after a fixed pipeline delay, matching the responder side.
- Used where a local sequencer, UART bridge or test engine drives the bus in place of the UDP bridge.
- Supports single and burst transactions on consecutive addresses.

Parameters:
- AW, 24, localbus address width.
- DW, 32, localbus data width.
- READ_DELAY, 3, cycles from read strobe to valid lb_rdata (equals the responder pipeline length). Minimum 1.
- LENW, 8, burst length field width.

Ports:
- clk  input  1  localbus clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  request accepted when valid&ready.
- req_addr  input  AW  start address.
- req_wdata  input  DW  write data (fill value for write bursts).
- req_rnw  input  1  1=read, 0=write.
- req_len  input  LENW  beats minus one.
- rsp_valid  output  1  response word available.
- rsp_ready  input  1  response consumed when valid&ready.
- rsp_rdata  output  DW  read data (0 for write ack).
- rsp_last  output  1  final response of the request.
- lb_addr  output  AW  bus address.
- lb_wdata  output  DW  bus write data.
- lb_write  output  1  write qualifier, high only with strobe.
- lb_control_strobe  output  1  one-cycle bus strobe per beat.
- lb_control_rd  output  1  read qualifier, high only with strobe.
- lb_rdata  input  DW  bus read data.
- lb_rvalid  output  1  pulse in the cycle lb_rdata is captured.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous, rst_n low forces state IDLE.
  - All outputs reset to 0, except req_ready=1.
  - Counters and registers clear.
  - Reset mid-burst abandons the transaction; no further strobes or responses.
- All outputs are registered.
- FSM states: IDLE, STROBE, WAIT, RESP, WFILL.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, wdata, rnw and len into beat counter; req_ready drops next cycle.
  - Go to STROBE if read, WFILL if write.
- Read path:
  - STROBE (1 cycle): lb_control_strobe=1, lb_control_rd=1, lb_write=0, lb_addr=current addr. Then WAIT.
  - WAIT: delay counter runs so lb_rdata is sampled exactly READ_DELAY cycles after the strobe cycle. Capture into rsp_rdata and pulse lb_rvalid in that cycle. Then RESP.
  - RESP: rsp_valid=1, rsp_rdata held stable until rsp_ready. rsp_last=1 when beat counter==0.
  - On handshake: if last, go to IDLE; else addr+1 and counter-1, go to STROBE next cycle.
  - No new strobe is issued while a response is pending; one outstanding read at most.
  - Minimum read beat period: READ_DELAY+2 cycles with rsp_ready held high.
- Write path:
  - WFILL: one strobe per cycle, back-to-back, each with lb_write=1, lb_control_rd=0, lb_wdata=latched wdata, lb_addr incrementing by 1.
  - After len+1 strobes, go to RESP with rsp_rdata=0, rsp_last=1. A single ack response per write request.
- Address arithmetic:
  - Increments modulo 2^AW; 0xFFFFFF wraps to 0x000000 for AW=24.
  - req_len=2^LENW-1 gives 256 beats for LENW=8.
- Qualifiers: lb_write and lb_control_rd are 0 whenever lb_control_strobe=0.
- Backpressure: rsp_ready low only stalls in RESP; it never suppresses or repeats a bus strobe.
- Ignored inputs: req_valid is ignored outside IDLE. lb_rdata is ignored except at the capture cycle.

Test Plan:
- Single read: addr 0x000010, len 0, responder returns 0xCAFEF00D with a 3-cycle delay. Expect one strobe with rd=1, capture 3 cycles later, rsp_rdata=0xCAFEF00D, rsp_last=1.
- Read burst: addr 0x000100, len 3, rsp_ready toggled randomly. Expect strobes at addresses 0x100 through 0x103, each issued only after the prior response is handshaken. Expect 4 responses matching the model, with rsp_last only on the 4th.
- Write fill: addr 0x004000, wdata 0x42, len 4. Expect 5 consecutive strobe cycles with write=1 at 0x4000 through 0x4004, then exactly one response with rdata=0, last=1.
- Wrap: read burst at addr 0xFFFFFE, len 2. Expect addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
- Reset mid-burst: assert rst_n low during WAIT of beat 2 of a len-7 read. Expect all outputs 0 immediately, req_ready=1 after release, no stray strobes, and a fresh single write completing normally.
- READ_DELAY=1 build: single read. Expect capture in the cycle after the strobe and a 3-cycle beat period with rsp_ready high.
